// File: rtl/wallace_mult_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace-tree multiplier.
// The CSA layer helpers count the rows of the reduction tree, which are WIDTH partial products plus one constant row.
package wallace_mult_pipe_pkg;

    localparam int   PIPE_DEPTH  = 3;
    localparam logic PRODUCT_RST = 1'b0;

    // Each 3:2 layer turns every full group of three rows into two rows.
    // Rows left over when the count is not a multiple of three pass through unchanged.
    function automatic int rows_after(input int width, input int layers);
        int n;
        n = width + 1;
        for (int l = 0; l < layers; l++) begin
            if (n > 2) n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int csa_layers(input int width);
        int n;
        int l;
        n = width + 1;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_3to2.sv
// Bit-vector 3:2 carry-save compressor.
// The carry output is already shifted to its own weight, and the bit shifted out at the top is dropped.
module csa_3to2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                    (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                    (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned per transaction.
// Optional accumulator on the output handshake: define WALLACE_MULT_ACC_EN.
module wallace_mult_pipe
    import wallace_mult_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    input  logic               out_ready
`ifdef WALLACE_MULT_ACC_EN
    ,
    input  logic               acc_clr,
    output logic [2*WIDTH-1:0] acc
`endif
);

    localparam int P      = 2 * WIDTH;
    localparam int LAYERS = csa_layers(WIDTH);
    localparam int SPLIT  = (LAYERS + 1) / 2;
    localparam int N0     = WIDTH + 1;
    localparam int N1     = rows_after(WIDTH, SPLIT);
    localparam int N2     = rows_after(WIDTH, LAYERS);
    // Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1), modulo 2^(2*WIDTH).
    localparam logic [P-1:0] BW_CONST = (P'(1) << (P - 1)) | (P'(1) << WIDTH);

    logic                  en;
    logic [PIPE_DEPTH-1:0] vld;
    logic [P-1:0]          pp      [N0];
    logic [P-1:0]          s1_rows [N1];
    logic [P-1:0]          s2_rows [N2];

    assign out_valid = vld[PIPE_DEPTH-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    // The sign-mixing terms (exactly one operand MSB involved) are inverted in signed mode.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        logic [P-1:0] row;
        always_comb begin
            row = '0;
            for (int j = 0; j < WIDTH; j++) begin
                row[i+j] = (a[j] & b[i]) ^ (sgn & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        assign pp[i] = row;
    end
    assign pp[WIDTH] = sgn ? BW_CONST : '0;

    // Layers below SPLIT run combinationally ahead of the S1 register, and the rest run ahead of S2.
    for (genvar l = 0; l < LAYERS; l++) begin : g_lyr
        localparam int NI = rows_after(WIDTH, l);
        localparam int NO = rows_after(WIDTH, l + 1);
        localparam int NG = NI / 3;
        logic [P-1:0] src  [NI];
        logic [P-1:0] rows [NO];

        if (l == 0) begin : g_src_pp
            assign src = pp;
        end else if (l == SPLIT) begin : g_src_s1
            assign src = s1_rows;
        end else begin : g_src_prev
            assign src = g_lyr[l-1].rows;
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_3to2 #(.WIDTH(P)) u_csa (
                .x     (src[3*g]),
                .y     (src[3*g+1]),
                .z     (src[3*g+2]),
                .sum   (rows[2*g]),
                .carry (rows[2*g+1])
            );
        end
        for (genvar r = 3 * NG; r < NI; r++) begin : g_pass
            assign rows[2*NG+r-3*NG] = src[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[PIPE_DEPTH-2:0], in_valid};
        end
    end

    // NOTE: the row registers have no reset because the valid bits qualify them, so a stale row is never observed.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_rows <= g_lyr[SPLIT-1].rows;
            s2_rows <= g_lyr[LAYERS-1].rows;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= {P{PRODUCT_RST}};
        end else if (en && vld[PIPE_DEPTH-2]) begin
            product <= s2_rows[0] + s2_rows[1];
        end
    end

`ifdef WALLACE_MULT_ACC_EN
    logic [PIPE_DEPTH-1:0] clr_pipe;

    always_ff @(posedge clk) begin
        if (en) clr_pipe <= {clr_pipe[PIPE_DEPTH-2:0], acc_clr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (out_valid && out_ready) begin
            acc <= clr_pipe[PIPE_DEPTH-1] ? product : acc + product;
        end
    end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe at WIDTH 32 (directed cases) and at WIDTH 8 and 13 (randomised cases).
// Accumulator checks are compiled in when WALLACE_MULT_ACC_EN is defined.
module tb_wallace_mult_pipe;

    typedef struct {
        logic [127:0] p;
        bit           clr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] a32 = '0, b32 = '0;
    logic        sgn32 = 1'b0, iv32 = 1'b0, or32 = 1'b1, clr32 = 1'b0;
    logic        ir32, ov32;
    logic [63:0] p32, acc32;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        sgn8 = 1'b0, iv8 = 1'b0, or8 = 1'b1, clr8 = 1'b0;
    logic        ir8, ov8;
    logic [15:0] p8, acc8;

    logic [12:0] a13 = '0, b13 = '0;
    logic        sgn13 = 1'b0, iv13 = 1'b0, or13 = 1'b1, clr13 = 1'b0;
    logic        ir13, ov13;
    logic [25:0] p13, acc13;

    exp_t q32[$];
    exp_t q8[$];
    exp_t q13[$];
    bit   done8 = 1'b0, done13 = 1'b0;

    wallace_mult_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .sgn(sgn32), .in_valid(iv32), .in_ready(ir32),
        .product(p32), .out_valid(ov32), .out_ready(or32)
`ifdef WALLACE_MULT_ACC_EN
        , .acc_clr(clr32), .acc(acc32)
`endif
    );

    wallace_mult_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sgn(sgn8), .in_valid(iv8), .in_ready(ir8),
        .product(p8), .out_valid(ov8), .out_ready(or8)
`ifdef WALLACE_MULT_ACC_EN
        , .acc_clr(clr8), .acc(acc8)
`endif
    );

    wallace_mult_pipe #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .sgn(sgn13), .in_valid(iv13), .in_ready(ir13),
        .product(p13), .out_valid(ov13), .out_ready(or13)
`ifdef WALLACE_MULT_ACC_EN
        , .acc_clr(clr13), .acc(acc13)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: extend the operands to 128 bits by their mode, multiply, keep 2*w bits.
    function automatic logic [127:0] model(input int w, input logic [63:0] x, input logic [63:0] y, input bit s);
        logic signed [127:0] xe, ye, r;
        logic [127:0] mask;
        for (int k = 0; k < 128; k++) begin
            xe[k] = (k < w) ? x[k] : (s ? x[w-1] : 1'b0);
            ye[k] = (k < w) ? y[k] : (s ? y[w-1] : 1'b0);
        end
        r    = xe * ye;
        mask = (128'(1) << (2 * w)) - 128'(1);
        return r & mask;
    endfunction

    task automatic send32(input logic [31:0] x, input logic [31:0] y, input bit s, input logic [127:0] e);
        int n;
        exp_t t;
        a32 = x; b32 = y; sgn32 = s; iv32 = 1'b1; n = 0;
        @(negedge clk);
        while (!ir32 && n < 200) begin @(negedge clk); n++; end
        if (!ir32) begin
            checks++; errors++;
            $display("FAIL send32 timeout: in_ready %0b, expected 1", ir32);
        end else begin
            t.p = e; t.clr = 1'b0;
            q32.push_back(t);
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input bit s, input bit c);
        int n;
        exp_t t;
        a8 = x; b8 = y; sgn8 = s; clr8 = c; iv8 = 1'b1; n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin @(negedge clk); n++; end
        if (!ir8) begin
            checks++; errors++;
            $display("FAIL send8 timeout: in_ready %0b, expected 1", ir8);
        end else begin
            t.p = model(8, 64'(x), 64'(y), s); t.clr = c;
            q8.push_back(t);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send13(input logic [12:0] x, input logic [12:0] y, input bit s);
        int n;
        exp_t t;
        a13 = x; b13 = y; sgn13 = s; iv13 = 1'b1; n = 0;
        @(negedge clk);
        while (!ir13 && n < 200) begin @(negedge clk); n++; end
        if (!ir13) begin
            checks++; errors++;
            $display("FAIL send13 timeout: in_ready %0b, expected 1", ir13);
        end else begin
            t.p = model(13, 64'(x), 64'(y), s); t.clr = 1'b0;
            q13.push_back(t);
        end
        @(posedge clk); #1;
        iv13 = 1'b0;
    endtask

    // Monitors: compare on every output handshake and check that product holds while stalled.
    logic [63:0] held_p32;
    bit          stall32 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            stall32 = 1'b0;
        end else begin
            if (stall32) begin
                check("hold_valid32", 128'(ov32), 128'(1));
                check("hold_prod32", 128'(p32), 128'(held_p32));
            end
            stall32  = ov32 && !or32;
            held_p32 = p32;
            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out32 unexpected: product %0h with nothing outstanding", p32);
                end else begin
                    exp_t t;
                    t = q32.pop_front();
                    check("prod32", 128'(p32), t.p);
                end
            end
        end
    end

    logic [15:0] racc8 = '0;
    bit          acc_pend8 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            racc8     = '0;
            acc_pend8 = 1'b0;
        end else begin
`ifdef WALLACE_MULT_ACC_EN
            if (acc_pend8) check("acc8", 128'(acc8), 128'(racc8));
`endif
            acc_pend8 = 1'b0;
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out8 unexpected: product %0h with nothing outstanding", p8);
                end else begin
                    exp_t t;
                    t = q8.pop_front();
                    check("prod8", 128'(p8), t.p);
                    racc8     = t.clr ? t.p[15:0] : racc8 + t.p[15:0];
                    acc_pend8 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q13.delete();
        end else if (ov13 && or13) begin
            if (q13.size() == 0) begin
                checks++; errors++;
                $display("FAIL out13 unexpected: product %0h with nothing outstanding", p13);
            end else begin
                exp_t t;
                t = q13.pop_front();
                check("prod13", 128'(p13), t.p);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid32", 128'(ov32), 128'(0));
        check("rst_product32", 128'(p32), 128'(0));
        check("rst_out_valid8", 128'(ov8), 128'(0));
        check("rst_product13", 128'(p13), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back unsigned transactions: fixed latency and a continuous out_valid.
        send32(32'd25, 32'd8, 1'b0, 128'd200);
        send32(32'd324223, 32'd3254567, 1'b0, 128'd1055205476441);
        send32(32'd18487, 32'd842, 1'b0, 128'd15566054);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("latency_valid_c%0d", k), 128'(ov32), 128'(1));
        end
        @(negedge clk);
        check("latency_valid_c6", 128'(ov32), 128'(0));
        @(posedge clk); #1;

        // Signed and unsigned corners.
        send32(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0, 128'hAAAA_AAA9_5555_5556);
        send32(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b1, 128'h0000_0000_5555_5556);
        send32(32'h8000_0000, 32'h8000_0000, 1'b1, 128'h4000_0000_0000_0000);
        send32(32'h8000_0000, 32'h0000_0001, 1'b1, 128'hFFFF_FFFF_8000_0000);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: hold out_ready low for 5 cycles once the first result appears.
        fork
            begin
                send32(32'd7, 32'd9, 1'b0, 128'd63);
                send32(32'hFFFF_FFF9, 32'd9, 1'b1, model(32, 64'hFFFF_FFF9, 64'd9, 1'b1));
                send32(32'd123456, 32'd654321, 1'b0, model(32, 64'd123456, 64'd654321, 1'b0));
                send32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, model(32, 64'h7FFF_FFFF, 64'h8000_0000, 1'b1));
            end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!ov32 && n < 50);
                check("bp_first_valid", 128'(ov32), 128'(1));
                @(posedge clk); #1;
                or32 = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 128'(ir32), 128'(0));
                end
                @(posedge clk); #1;
                or32 = 1'b1;
            end
        join
        n = 0;
        while (q32.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("bp_all_delivered", 128'(q32.size()), 128'(0));
        @(posedge clk); #1;

        // Reset with two transactions in flight: nothing may emerge afterwards.
        send32(32'd11, 32'd13, 1'b0, 128'd143);
        send32(32'd17, 32'd19, 1'b0, 128'd323);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("midrst_out_valid", 128'(ov32), 128'(0));
            check("midrst_product", 128'(p32), 128'(0));
        end
        @(posedge clk); #1;

`ifdef WALLACE_MULT_ACC_EN
        send8(8'd3, 8'd4, 1'b0, 1'b1);
        send8(8'd5, 8'd6, 1'b0, 1'b0);
        send8(8'd255, 8'd255, 1'b0, 1'b0);
        send8(8'd2, 8'd2, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("acc8_final", 128'(acc8), 128'd4);
`endif

        // Randomised sweeps at widths 8 and 13 with random gaps and random out_ready.
        fork
            begin
                for (int t = 0; t < 200; t++) begin
                    logic [31:0] x, y;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    x = $urandom; y = $urandom;
                    send8(x[7:0], y[7:0], 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                end
                done8 = 1'b1;
            end
            begin
                while (!done8) begin @(posedge clk); #1; or8 = $urandom_range(0, 3) != 0; end
                or8 = 1'b1;
            end
            begin
                for (int t = 0; t < 200; t++) begin
                    logic [31:0] x, y;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    x = $urandom; y = $urandom;
                    if (t < 4) begin
                        x = (t % 2 == 0) ? 32'h1000 : 32'h1FFF;
                        y = (t < 2) ? 32'h1000 : 32'h0FFF;
                    end
                    send13(x[12:0], y[12:0], 1'($urandom_range(0, 1)));
                end
                done13 = 1'b1;
            end
            begin
                while (!done13) begin @(posedge clk); #1; or13 = $urandom_range(0, 3) != 0; end
                or13 = 1'b1;
            end
        join

        n = 0;
        while ((q32.size() + q8.size() + q13.size()) != 0 && n < 500) begin @(negedge clk); n++; end
        check("drain32", 128'(q32.size()), 128'(0));
        check("drain8", 128'(q8.size()), 128'(0));
        check("drain13", 128'(q13.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier. Supersedes the fixed 32-bit combinational multiplier.
- Adds a selectable signed/unsigned mode per transaction, a three-stage register pipeline, and valid/ready handshakes on both sides.
- Sits between operand producers and datapath consumers that need one full-width product per cycle at a fixed latency.

Parameters:
- WIDTH, 32: operand width in bits; legal range 4..64; product is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- sgn  input  1  1 = two's-complement operands, 0 = unsigned
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- product  output  2*WIDTH  full-precision product
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product this cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: all stage valid bits = 0, out_valid = 0, product = 0. Reset mid-operation discards every in-flight transaction; nothing emerges after reset deasserts.
- Pipeline structure:
  - S1: partial-product generation plus first CSA layers.
  - S2: remaining CSA layers down to two rows.
  - S3: final carry-propagate add into the product register.
- Enable: en = !out_valid || out_ready. in_ready = en, combinational; in_ready is not registered.
- When en = 1, all stages shift together. Input is captured when in_valid && in_ready. Bubbles are not collapsed.
- When en = 0, every stage register (data and valid) holds. product and out_valid stay stable until the handshake.
- Latency: product is visible 3 cycles after acceptance, provided no stall occurs.
- Throughput: 1 product per cycle with out_ready held at 1.
- Arithmetic:
  - Unsigned: product = a*b, exact over 2*WIDTH bits.
  - Signed: Baugh-Wooley partial products; the result is the exact two's-complement product over 2*WIDTH bits.
  - No overflow is possible, so there is no carry-out port.
- sgn travels with its operands. Back-to-back transactions of mixed mode are independent.
- in_valid = 0 while en = 1 inserts a bubble; the corresponding output cycle has out_valid = 0.

Optional Feature:
- Macro: WALLACE_MULT_ACC_EN.
- When defined, the block adds:
  - input acc_clr (1 bit), sampled with the operands and pipelined alongside them.
  - output acc (2*WIDTH bits).
- Accumulator update on each output handshake (out_valid && out_ready):
  - acc <= acc_clr_of_that_txn ? product : acc + product.
  - Addition wraps modulo 2^(2*WIDTH).
  - acc resets to 0 and is unchanged on any cycle without a handshake.
- When undefined: no acc_clr or acc ports and no accumulator logic. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - a function computing the CSA layer count for a given WIDTH;
  - a constant for the pipeline depth (3);
  - the reset value of product (0).
- Sub-module csa_3to2: bit-vector 3:2 carry-save compressor, parametrised by width. It is instantiated per reduction layer inside the S1/S2 generate loops.

Test Plan:
- WIDTH=32, sgn=0, out_ready=1, inputs (25,8), (324223,3254567), (18487,842) on consecutive cycles -> products 200, 1055205476441, 15566054 on cycles 3, 4, 5 after first acceptance, out_valid continuous.
- WIDTH=32, a=0xFFFFFFFF, b=0xAAAAAAAA -> sgn=0 gives 0xAAAAAAA955555556; sgn=1 gives 0x0000000055555556.
- WIDTH=32, sgn=1, a=b=0x80000000 -> 0x4000000000000000. Then a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
- Backpressure: stream 4 operand pairs, drop out_ready for 5 cycles once out_valid rises -> in_ready=0 during the stall, product held stable, all 4 results delivered in order with none lost or duplicated.
- Reset mid-operation: accept 2 transactions, assert rst for 1 cycle before either emerges -> out_valid stays 0 for the next 5 cycles, product = 0.
- WALLACE_MULT_ACC_EN, WIDTH=8, sgn=0: (3,4,clr=1), (5,6,clr=0), (255,255,clr=0) -> acc = 12, 42, 65067. Then (2,2,clr=1) -> acc = 4.
- Randomised sweep at WIDTH=8 and WIDTH=13, both sgn values, against a behavioural a*b model.
